// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT streaming flow controllers.
// The state encoding is fixed so that sibling controllers can share it.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_t;

    // In these states the controller injects zeros instead of taking input.
    function automatic logic is_flush(input ctrl_state_t st);
        return (st == ST_PAD) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/brev_flow_ctrl_if.sv
// Upstream, downstream and bit-reverse-buffer signals of brev_flow_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface brev_flow_ctrl_if #(
    parameter int WIDTH = 24
);
    logic                 i_valid;
    logic                 o_ready;
    logic [2*WIDTH-1:0]   i_data;
    logic                 i_last;
    logic                 o_brev_reset;
    logic                 o_brev_ce;
    logic [2*WIDTH-1:0]   o_brev_in;
    logic [2*WIDTH-1:0]   i_brev_out;
    logic                 o_valid;
    logic                 i_ready;
    logic [2*WIDTH-1:0]   o_data;
    logic                 o_sync;
    logic                 o_last;

    modport slave (
        input  i_valid, i_data, i_last, i_brev_out, i_ready,
        output o_ready, o_brev_reset, o_brev_ce, o_brev_in,
               o_valid, o_data, o_sync, o_last
    );

    modport master (
        output i_valid, i_data, i_last, i_brev_out, i_ready,
        input  o_ready, o_brev_reset, o_brev_ce, o_brev_in,
               o_valid, o_data, o_sync, o_last
    );
endinterface

// File: rtl/brev_flow_ctrl_frame_counter.sv
// Wrapping sample index within an N = 2**LGSIZE frame plus its terminal flag.
module frame_counter #(
    parameter int LGSIZE = 5
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    input  logic              i_enable,
    output logic [LGSIZE-1:0] o_idx,
    output logic              o_terminal
);
    logic [LGSIZE-1:0] idx_r;

    // Index register; natural binary overflow provides the N-1 -> 0 wrap.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            idx_r <= {LGSIZE{1'b0}};
        end else if (i_enable) begin
            idx_r <= idx_r + {{(LGSIZE-1){1'b0}}, 1'b1};
        end else begin
            idx_r <= idx_r;
        end
    end

    assign o_idx      = idx_r;
    assign o_terminal = (idx_r == {LGSIZE{1'b1}});
endmodule

// File: rtl/brev_flow_ctrl.sv
// Flow controller around an external bit-reverse buffer: handshakes, frame
// tracking, zero-padding of a short final frame and the trailing drain.
module brev_flow_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    brev_flow_ctrl_if.slave   bus
);
    ctrl_state_t         state_r;
    ctrl_state_t         state_nxt_s;
    logic                brev_reset_r;
    logic                primed_r;
    logic                valid_r;
    logic                sync_r;
    logic                last_r;
    logic                flushing_s;
    logic                out_free_s;
    logic                adv_s;
    logic                ready_s;
    logic [2*WIDTH-1:0]  brev_in_s;
    logic [LGSIZE-1:0]   idx_s;
    logic                terminal_s;

    frame_counter #(.LGSIZE(LGSIZE)) u_frame_counter (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_enable   (adv_s),
        .o_idx      (idx_s),
        .o_terminal (terminal_s)
    );

    // Advance qualification, upstream ready and buffer input steering.
    always_comb begin
        flushing_s = is_flush(state_r);
        out_free_s = !valid_r || bus.i_ready;
        adv_s      = !brev_reset_r && out_free_s && (bus.i_valid || flushing_s);
        ready_s    = !brev_reset_r && !flushing_s && out_free_s;
        if (flushing_s) begin
            brev_in_s = {(2*WIDTH){1'b0}};
        end else begin
            brev_in_s = bus.i_data;
        end
    end

    // Frame sequencing; every transition happens on an advance.
    always_comb begin
        state_nxt_s = state_r;
        if (adv_s) begin
            case (state_r)
                ST_FILL, ST_RUN: begin
                    if (terminal_s) begin
                        state_nxt_s = bus.i_last ? ST_DRAIN : ST_RUN;
                    end else if (bus.i_last) begin
                        state_nxt_s = ST_PAD;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_PAD: begin
                    state_nxt_s = terminal_s ? ST_DRAIN : ST_PAD;
                end
                ST_DRAIN: begin
                    state_nxt_s = terminal_s ? ST_FILL : ST_DRAIN;
                end
                default: begin
                    state_nxt_s = ST_FILL;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, buffer reset and registered downstream flags.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_r      <= ST_FILL;
            brev_reset_r <= 1'b1;
            primed_r     <= 1'b0;
            valid_r      <= 1'b0;
            sync_r       <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            brev_reset_r <= 1'b0;
            state_r      <= state_nxt_s;
            // The buffer holds a full previous frame once a frame completes.
            if (adv_s && terminal_s) begin
                primed_r <= (state_r != ST_DRAIN);
            end else begin
                primed_r <= primed_r;
            end
            if (adv_s) begin
                valid_r <= primed_r;
                sync_r  <= primed_r && (idx_s == {LGSIZE{1'b0}});
                last_r  <= (state_r == ST_DRAIN) && terminal_s;
            end else if (bus.i_ready) begin
                valid_r <= 1'b0;
                sync_r  <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                valid_r <= valid_r;
                sync_r  <= sync_r;
                last_r  <= last_r;
            end
        end
    end

    assign bus.o_brev_reset = brev_reset_r;
    assign bus.o_brev_ce    = adv_s;
    assign bus.o_brev_in    = brev_in_s;
    assign bus.o_ready      = ready_s;
    assign bus.o_valid      = valid_r;
    assign bus.o_sync       = sync_r;
    assign bus.o_last       = last_r;
    assign bus.o_data       = bus.i_brev_out;
endmodule

// File: tb/tb_brev_flow_ctrl.sv
// Randomized bench for brev_flow_ctrl with an external ping-pong bit-reverse
// buffer and a frame-level reference model of the expected output stream.
module tb_brev_flow_ctrl;
    localparam int LG = 3;
    localparam int N  = 8;
    localparam int W  = 16;
    localparam int DW = 2 * W;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    brev_flow_ctrl_if #(.WIDTH(W)) bus ();

    brev_flow_ctrl #(.LGSIZE(LG), .WIDTH(W)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .bus        (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [LG-1:0] brev_idx(input logic [LG-1:0] v);
        logic [LG-1:0] r;
        for (int b = 0; b < LG; b++) r[LG-1-b] = v[b];
        return r;
    endfunction

    // Buffer model: writes frame f into one bank while reading frame f-1 reversed.
    logic [DW-1:0] bmem [2][N];
    logic [LG-1:0] bcnt;
    logic          bbank;
    always @(posedge clk) begin
        if (bus.o_brev_reset) begin
            bcnt  <= '0;
            bbank <= 1'b0;
        end else if (bus.o_brev_ce) begin
            bmem[bbank][bcnt] <= bus.o_brev_in;
            bus.i_brev_out    <= bmem[~bbank][brev_idx(bcnt)];
            bcnt              <= bcnt + 3'd1;
            if (bcnt == 3'(N-1)) bbank <= ~bbank;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [DW-1:0] stim [$];
    logic [DW-1:0] exp_d [$];
    logic          exp_s [$];
    logic          exp_l [$];

    // Each frame (the last one zero-padded to N) reappears bit-reversed in order.
    task automatic build_expected(input int len);
        int frames;
        int src;
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        frames = (len + N - 1) / N;
        for (int f = 0; f < frames; f++) begin
            for (int p = 0; p < N; p++) begin
                src = f * N + int'(brev_idx(LG'(p)));
                exp_d.push_back(src < len ? stim[src] : '0);
                exp_s.push_back(p == 0);
                exp_l.push_back((f == frames - 1) && (p == N - 1));
            end
        end
    endtask

    task automatic run_stream(input int len, input int pv, input int pr,
                              input int abort_at, input bit directed, input bit hold4);
        int in_ptr = 0;
        int out_ptr = 0;
        int cyc = 0;
        int remaining;
        int hold_left = 0;
        bit held = 1'b0;
        bit stalled = 1'b0;
        logic [DW-1:0] hold_d = '0;
        stim.delete();
        for (int i = 0; i < len; i++) stim.push_back(directed ? DW'(i) : DW'($urandom));
        build_expected(len);
        while ((in_ptr < len || out_ptr < exp_d.size()) && cyc < BUDGET) begin
            @(negedge clk);
            remaining = exp_d.size() - out_ptr;
            if (hold4 && !held && out_ptr == 3) begin
                hold_left = 4;
                held = 1'b1;
            end
            bus.i_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(99) < pr);
            if (hold_left > 0) hold_left--;
            if (in_ptr < len) begin
                bus.i_valid = ($urandom_range(99) < pv);
                bus.i_data  = stim[in_ptr];
                bus.i_last  = (in_ptr == len - 1);
            end else begin
                bus.i_valid = (remaining > 1) && ($urandom_range(1) == 1);
                bus.i_data  = DW'($urandom);
                bus.i_last  = ($urandom_range(1) == 1);
            end
            #1;
            if (stalled) begin
                chk("stall_valid", bus.o_valid, 1'b1);
                chk("stall_data", bus.o_data, hold_d);
            end
            if (bus.o_valid && !bus.i_ready) begin
                chk("stall_ce", bus.o_brev_ce, 1'b0);
                chk("stall_ready", bus.o_ready, 1'b0);
                stalled = 1'b1;
                hold_d  = bus.o_data;
            end else begin
                stalled = 1'b0;
            end
            if (in_ptr >= len && remaining > 1) chk("flush_ready", bus.o_ready, 1'b0);
            if (bus.o_valid && bus.i_ready) begin
                if (out_ptr < exp_d.size()) begin
                    chk("out_data", bus.o_data, exp_d[out_ptr]);
                    chk("out_sync", bus.o_sync, exp_s[out_ptr]);
                    chk("out_last", bus.o_last, exp_l[out_ptr]);
                end else begin
                    chk("extra_out", 1'b1, 1'b0);
                end
                out_ptr++;
            end
            if (bus.i_valid && bus.o_ready && in_ptr < len) in_ptr++;
            cyc++;
            if (abort_at > 0 && in_ptr == abort_at) return;
        end
        chk("stream_timeout", cyc < BUDGET, 1'b1);
        bus.i_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bus.i_ready = 1'b1;
            #1;
            chk("idle_valid", bus.o_valid, 1'b0);
            chk("idle_ce", bus.o_brev_ce, 1'b0);
        end
        chk("back_to_fill", bus.o_ready, 1'b1);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_sync", bus.o_sync, 1'b0);
        chk("rst_last", bus.o_last, 1'b0);
        chk("rst_brev_reset", bus.o_brev_reset, 1'b1);
        chk("rst_ready", bus.o_ready, 1'b0);
        chk("rst_ce", bus.o_brev_ce, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_brev_reset", bus.o_brev_reset, 1'b1);
        chk("rel_ce", bus.o_brev_ce, 1'b0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("brev_reset_low", bus.o_brev_reset, 1'b0);

        run_stream(16, 100, 100, 0, 1'b1, 1'b0);
        run_stream(11, 100, 100, 0, 1'b1, 1'b0);
        run_stream(1, 100, 100, 0, 1'b1, 1'b0);
        run_stream(24, 100, 100, 0, 1'b1, 1'b1);
        run_stream(24, 50, 100, 0, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            run_stream($urandom_range(30, 1), $urandom_range(100, 30),
                       $urandom_range(100, 30), 0, 1'b0, 1'b0);
        end

        // Abort partway into the second frame and restart with a fresh stream.
        run_stream(16, 100, 100, 13, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        chk("mid_rst_valid", bus.o_valid, 1'b0);
        chk("mid_rst_brev_reset", bus.o_brev_reset, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        chk("mid_rel_brev_reset", bus.o_brev_reset, 1'b1);
        chk("mid_rel_ce", bus.o_brev_ce, 1'b0);
        chk("mid_rel_valid", bus.o_valid, 1'b0);
        bus.i_valid = 1'b0;
        run_stream(8, 100, 100, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
